// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end
package fetch_pkg;
    localparam int ADDR_W = 32;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_ADDR = 32'd1040;
    typedef enum logic {IDLE, REQ} fsm_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INSTR_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; a push is accepted while full if a pop happens in the same cycle
module fetch_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic empty, wr, rd;
    always_comb begin
        empty = count == '0;
        rd = pop && !empty;
        wr = push && (count != (AW+1)'(DEPTH) || rd);
        dout = empty ? '0 : mem[rp];
    end
    always_ff @(posedge CLK) begin
        if (!RST || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    always_ff @(posedge CLK)
        if (wr) mem[wp] <= din;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with credit-limited memory reads and a redirect-flushable FIFO
// Optional FETCH_PERF_EN adds statFetched/statDropped counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = fetch_pkg::RESET_ADDR
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirectAddr,
    output logic               memReq,
    output logic [ADDR_W-1:0]  memAddr,
    input  logic               memGnt,
    input  logic               memRvalid,
    input  logic [INSTR_W-1:0] memRdata,
    output logic               instValid,
    output logic [INSTR_W-1:0] instData,
    output logic [ADDR_W-1:0]  instAddr,
`ifdef FETCH_PERF_EN
    output logic [31:0]        statFetched,
    output logic [31:0]        statDropped,
`endif
    input  logic               instReady
);
    localparam int CW = $clog2(DEPTH) + 1;
    fsm_t state;
    logic pend, gnt, hold, push, credit, credit_after;
    logic [ADDR_W-1:0] fetch_addr, pend_addr, resp_addr;
    logic [CW-1:0] occ, out, stale, occ_eff;
    entry_t head;
    // A redirecting cycle flushes the FIFO, so its occupancy no longer consumes credit
    always_comb begin
        gnt = state == REQ && memGnt;
        hold = state == REQ && !memGnt;
        push = memRvalid && stale == '0;
        occ_eff = redirect ? '0 : occ;
        credit = occ_eff + out < CW'(DEPTH);
        credit_after = occ_eff + out + CW'(1) < CW'(DEPTH);
        memReq = state == REQ;
        memAddr = fetch_addr;
        instValid = occ != '0;
        instAddr = head.addr;
        instData = head.data;
    end
    fetch_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .CLK(CLK), .RST(RST), .flush(redirect), .push(push), .din({resp_addr, memRdata}),
        .pop(instReady), .dout(head), .count(occ)
    );
    // Every granted read, stale or not, holds a slot here until its response returns
    fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_inflight (
        .CLK(CLK), .RST(RST), .flush(1'b0), .push(gnt), .din(fetch_addr),
        .pop(memRvalid), .dout(resp_addr), .count(out)
    );
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            pend <= 1'b0;
            pend_addr <= '0;
            fetch_addr <= RESET_ADDR;
            stale <= '0;
        end else begin
            stale <= redirect ? out + CW'(gnt) - CW'(memRvalid)
                              : stale - CW'(memRvalid && stale != '0) + CW'(gnt && pend);
            if (state == IDLE)
                state <= credit ? REQ : IDLE;
            else if (gnt)
                state <= credit_after ? REQ : IDLE;
            if (redirect && hold) begin
                pend <= 1'b1;
                pend_addr <= redirectAddr;
            end else if (redirect) begin
                pend <= 1'b0;
                fetch_addr <= redirectAddr;
            end else if (gnt) begin
                pend <= 1'b0;
                fetch_addr <= pend ? pend_addr : fetch_addr + 32'd4;
            end
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            statFetched <= '0;
            statDropped <= '0;
        end else begin
            statFetched <= statFetched + 32'(push && !redirect);
            statDropped <= statDropped + 32'(memRvalid && stale != '0)
                + (redirect ? 32'(occ) - 32'(instReady && occ != '0) + 32'(push) : 32'd0);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios with an in-order memory model and an instruction scoreboard
module tb_fetch_queue;
    logic CLK = 1'b0, RST = 1'b0, redirect = 1'b0, memGnt = 1'b0, memRvalid = 1'b0, instReady = 1'b0;
    logic [31:0] redirectAddr = '0, memRdata = '0;
    logic memReq, instValid;
    logic [31:0] memAddr, instData, instAddr;
`ifdef FETCH_PERF_EN
    logic [31:0] statFetched, statDropped;
`endif
    int n_cmp = 0, n_err = 0, grants = 0, g0 = 0;
    bit rv_en = 1'b1;
    logic [31:0] mq[$], exp_q[$];

    fetch_queue dut (
        .CLK(CLK), .RST(RST), .redirect(redirect), .redirectAddr(redirectAddr),
        .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt), .memRvalid(memRvalid),
        .memRdata(memRdata), .instValid(instValid), .instData(instData), .instAddr(instAddr),
`ifdef FETCH_PERF_EN
        .statFetched(statFetched), .statDropped(statDropped),
`endif
        .instReady(instReady)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start(input logic gnt, input logic rdy);
        RST = 1'b0;
        redirect = 1'b0;
        memGnt = gnt;
        instReady = rdy;
        rv_en = 1'b1;
        tick(2);
        RST = 1'b1;
        tick(1);
    endtask

    // Memory: grants are recorded at the negedge before the granting edge, answered one cycle later
    always @(negedge CLK) begin
        if (!RST) mq.delete();
        else if (memReq && memGnt) begin
            mq.push_back(memAddr);
            grants++;
        end
    end
    always begin
        @(posedge CLK);
        #2;
        memRvalid = 1'b0;
        memRdata = '0;
        if (rv_en && mq.size() != 0) begin
            memRvalid = 1'b1;
            memRdata = word(mq.pop_front());
        end
    end

    always @(negedge CLK) begin
        logic [31:0] a;
        if (RST && instValid && instReady) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_inst: got addr 0x%08h, want none", instAddr);
            end else begin
                a = exp_q.pop_front();
                chk("inst_addr", instAddr, a);
                chk("inst_data", instData, word(a));
            end
        end
    end

    initial begin
        memGnt = 1'b1;
        instReady = 1'b1;
        tick(3);
        chk("reset_memReq", 32'(memReq), 0);
        chk("reset_memAddr", memAddr, 32'd1040);
        chk("reset_instValid", 32'(instValid), 0);
        chk("reset_instData", instData, 0);
        chk("reset_instAddr", instAddr, 0);
        // streaming: one instruction per cycle, 8 grants
        for (int i = 0; i < 8; i++) exp_q.push_back(32'd1040 + 32'(4 * i));
        RST = 1'b1;
        tick();
        chk("s1_first_req", 32'(memReq), 1);
        chk("s1_addr0", memAddr, 32'd1040);
        tick();
        chk("s1_addr1", memAddr, 32'd1044);
        tick();
        chk("s1_first_valid", 32'(instValid), 1);
        chk("s1_first_inst", instAddr, 32'd1040);
        for (int k = 4; k <= 6; k++) begin
            tick();
            chk("s1_stream", instAddr, 32'd1040 + 32'(4 * (k - 3)));
        end
        tick(3);
        memGnt = 1'b0;
        tick(6);
        chk("s1_hold_req", 32'(memReq), 1);
        chk("s1_hold_addr", memAddr, 32'd1072);
        // full FIFO with instReady low
        g0 = grants;
        start(1'b1, 1'b0);
        tick(9);
        chk("s2_grants", 32'(grants - g0), 4);
        chk("s2_req_low", 32'(memReq), 0);
        chk("s2_addr", memAddr, 32'd1056);
        chk("s2_head", instAddr, 32'd1040);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'd1040 + 32'(4 * i));
        instReady = 1'b1;
        tick(2);
        chk("s2_resume_req", 32'(memReq), 1);
        chk("s2_resume_addr", memAddr, 32'd1056);
        tick();
        memGnt = 1'b0;
        tick(8);
        chk("s2_grants_total", 32'(grants - g0), 5);
        // redirect with two reads outstanding and two entries queued
        start(1'b1, 1'b0);
        tick(3);
        rv_en = 1'b0;
        tick();
        chk("s3_idle", 32'(memReq), 0);
        chk("s3_idle_addr", memAddr, 32'd1056);
        redirect = 1'b1;
        redirectAddr = 32'h200;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        tick();
        redirect = 1'b0;
        chk("s3_req_next", 32'(memReq), 1);
        chk("s3_new_addr", memAddr, 32'h200);
        chk("s3_flushed", 32'(instValid), 0);
        instReady = 1'b1;
        rv_en = 1'b1;
        tick(2);
        memGnt = 1'b0;
        tick();
        chk("s3_first_inst", instAddr, 32'h200);
`ifdef FETCH_PERF_EN
        chk("s3_stat_dropped", statDropped, 4);
        chk("s3_stat_fetched", statFetched, 3);
`endif
        tick(6);
        // redirect while a request waits for grant
        start(1'b0, 1'b1);
        redirect = 1'b1;
        redirectAddr = 32'h200;
        exp_q.push_back(32'h200);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("s4_held_addr", memAddr, 32'd1040);
            chk("s4_held_req", 32'(memReq), 1);
        end
        memGnt = 1'b1;
        tick();
        chk("s4_pend_addr", memAddr, 32'h200);
        tick();
        memGnt = 1'b0;
        tick(6);
        // address wrap
        start(1'b1, 1'b1);
        redirect = 1'b1;
        redirectAddr = 32'hFFFF_FFF8;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        chk("s5_addr_f8", memAddr, 32'hFFFF_FFF8);
        tick();
        chk("s5_addr_fc", memAddr, 32'hFFFF_FFFC);
        tick();
        chk("s5_wrap", memAddr, 32'h0);
        memGnt = 1'b0;
        tick(6);
        // reset mid-burst
        start(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd1040 + 32'(4 * i));
        tick(5);
        RST = 1'b0;
        tick();
        chk("s6_rst_req", 32'(memReq), 0);
        chk("s6_rst_valid", 32'(instValid), 0);
        chk("s6_rst_addr", memAddr, 32'd1040);
`ifdef FETCH_PERF_EN
        chk("s6_rst_stat", statFetched, 0);
`endif
        RST = 1'b1;
        exp_q.push_back(32'd1040);
        exp_q.push_back(32'd1044);
        tick();
        chk("s6_restart_req", 32'(memReq), 1);
        chk("s6_restart_addr", memAddr, 32'd1040);
        tick(2);
        memGnt = 1'b0;
        tick(6);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
